// File: rtl/latch_wr_sched_pkg.sv
// rtl/latch_wr_sched_pkg.sv - shared types and constants for the latch write scheduler
package latch_wr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int CNT_W   = 4;
    localparam int MAX_CYC = 15;

    // Window counters hold "cycles remaining after this one", so a window of n loads n-1.
    function automatic logic [CNT_W-1:0] last_cnt(input int cycles);
        return (cycles > 0) ? CNT_W'(cycles - 1) : '0;
    endfunction

endpackage

// File: rtl/latch_wr_sched_if.sv
// rtl/latch_wr_sched_if.sv - requester/latch-bank bundle; LATCH_WR_SCHED_VERIFY_EN adds latch_q/err
interface latch_wr_sched_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic                   done;
    logic                   busy;
    logic [WIDTH-1:0]       latch_d;
    logic                   latch_en;

`ifdef LATCH_WR_SCHED_VERIFY_EN
    logic [WIDTH-1:0]       latch_q;
    logic                   err;

    modport master (
        output req, wdata, latch_q,
        input  gnt, done, busy, latch_d, latch_en, err
    );
    modport slave (
        input  req, wdata, latch_q,
        output gnt, done, busy, latch_d, latch_en, err
    );
`else
    modport master (
        output req, wdata,
        input  gnt, done, busy, latch_d, latch_en
    );
    modport slave (
        input  req, wdata,
        output gnt, done, busy, latch_d, latch_en
    );
`endif

endinterface

// File: rtl/latch_wr_sched_rr_arbiter.sv
// rtl/latch_wr_sched_rr_arbiter.sv - round-robin pick from a registered pointer
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    input  logic [IDX_W-1:0] last_idx,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [IDX_W-1:0] ptr;

    // First active request scanning upward from ptr, wrapping past N_REQ-1.
    always_comb begin
        int idx;
        idx    = 0;
        grant  = '0;
        winner = '0;
        valid  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!valid && req[idx]) begin
                valid      = 1'b1;
                winner     = IDX_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(last_idx) == N_REQ - 1) ? '0 : last_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/latch_wr_sched.sv
// rtl/latch_wr_sched.sv - latch-bank write scheduler; LATCH_WR_SCHED_VERIFY_EN adds readback compare
module latch_wr_sched
    import latch_wr_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 2,
    parameter int OPEN_CYC  = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    latch_wr_sched_if.slave bus
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] SETUP_LAST = last_cnt(SETUP_CYC);
    localparam logic [CNT_W-1:0] OPEN_LAST  = last_cnt(OPEN_CYC);
    localparam logic [CNT_W-1:0] HOLD_LAST  = last_cnt(HOLD_CYC);
    localparam logic OPEN_ENDS = (HOLD_CYC == 0);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("latch_wr_sched: N_REQ must be 2..8");
    end
    if (OPEN_CYC < 1 || OPEN_CYC > MAX_CYC) begin : g_bad_open
        $error("latch_wr_sched: OPEN_CYC must be 1..15");
    end
    if (SETUP_CYC < 0 || SETUP_CYC > MAX_CYC) begin : g_bad_setup
        $error("latch_wr_sched: SETUP_CYC must be 0..15");
    end
    if (HOLD_CYC < 0 || HOLD_CYC > MAX_CYC) begin : g_bad_hold
        $error("latch_wr_sched: HOLD_CYC must be 0..15");
    end

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] cur_idx;
    logic [N_REQ-1:0] gnt_q;
    logic             done_q;
    logic             busy_q;
    logic             en_q;
    logic [WIDTH-1:0] d_q;

    logic [N_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    // done_q is high only in the final cycle of a write, so it doubles as the pointer advance.
    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (bus.req),
        .advance  (done_q),
        .last_idx (cur_idx),
        .grant    (pick_gnt),
        .winner   (pick_idx),
        .valid    (pick_valid)
    );

    // All outputs are registered one cycle ahead so done lands in the last window cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_idx <= '0;
            gnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            d_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_q   <= pick_gnt;
                        busy_q  <= 1'b1;
                        cur_idx <= pick_idx;
                        d_q     <= bus.wdata[int'(pick_idx)*WIDTH +: WIDTH];
                        if (SETUP_CYC > 0) begin
                            state <= SETUP;
                            cnt   <= SETUP_LAST;
                        end else begin
                            state  <= OPEN;
                            cnt    <= OPEN_LAST;
                            en_q   <= 1'b1;
                            done_q <= OPEN_ENDS && (OPEN_CYC == 1);
                        end
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state  <= OPEN;
                        cnt    <= OPEN_LAST;
                        en_q   <= 1'b1;
                        done_q <= OPEN_ENDS && (OPEN_CYC == 1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                OPEN: begin
                    if (cnt == '0) begin
                        en_q <= 1'b0;
                        if (OPEN_ENDS) begin
                            state  <= IDLE;
                            gnt_q  <= '0;
                            busy_q <= 1'b0;
                            done_q <= 1'b0;
                        end else begin
                            state  <= HOLD;
                            cnt    <= HOLD_LAST;
                            done_q <= (HOLD_CYC == 1);
                        end
                    end else begin
                        cnt    <= cnt - CNT_W'(1);
                        done_q <= OPEN_ENDS && (cnt == CNT_W'(1));
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state  <= IDLE;
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end else begin
                        cnt    <= cnt - CNT_W'(1);
                        done_q <= (cnt == CNT_W'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.latch_en = en_q;
    assign bus.latch_d  = d_q;

`ifdef LATCH_WR_SCHED_VERIFY_EN
    assign bus.err = done_q && (bus.latch_q != d_q);
`endif

endmodule

// File: tb/tb_latch_wr_sched.sv
// tb/tb_latch_wr_sched.sv - self-checking bench for latch_wr_sched (LATCH_WR_SCHED_VERIFY_EN optional)
module tb_latch_wr_sched;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int S  = 2;
    localparam int O  = 1;
    localparam int H  = 1;
    localparam int L  = S + O + H;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    latch_wr_sched_if #(.N_REQ(N), .WIDTH(W)) bus1 ();
    latch_wr_sched_if #(.N_REQ(N), .WIDTH(W)) bus2 ();

    latch_wr_sched #(.N_REQ(N), .WIDTH(W), .SETUP_CYC(S), .OPEN_CYC(O), .HOLD_CYC(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    latch_wr_sched #(.N_REQ(N), .WIDTH(W), .SETUP_CYC(0), .OPEN_CYC(3), .HOLD_CYC(0)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

`ifdef LATCH_WR_SCHED_VERIFY_EN
    logic q_zero = 1'b0;
    assign bus1.latch_q = q_zero ? '0 : bus1.latch_d;
    assign bus2.latch_q = bus2.latch_d;
`endif

    typedef struct {
        logic [N-1:0] req;
        logic [W-1:0] wd;
        logic [N-1:0] gnt;
        logic         busy;
        logic         en;
        logic         done;
        logic [W-1:0] d;
    } vec_t;

    vec_t tv1[7];
    vec_t tv2[6];

    int n_checks = 0;
    int n_fail   = 0;

    int           m_pos;
    int           m_ptr;
    int           m_win;
    logic [W-1:0] m_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_row(input string tag, input int which, input vec_t v);
        if (which == 1) begin
            chk({tag, ".gnt"},  32'(bus1.gnt),      32'(v.gnt));
            chk({tag, ".busy"}, 32'(bus1.busy),     32'(v.busy));
            chk({tag, ".en"},   32'(bus1.latch_en), 32'(v.en));
            chk({tag, ".done"}, 32'(bus1.done),     32'(v.done));
            chk({tag, ".d"},    32'(bus1.latch_d),  32'(v.d));
        end else begin
            chk({tag, ".gnt"},  32'(bus2.gnt),      32'(v.gnt));
            chk({tag, ".busy"}, 32'(bus2.busy),     32'(v.busy));
            chk({tag, ".en"},   32'(bus2.latch_en), 32'(v.en));
            chk({tag, ".done"}, 32'(bus2.done),     32'(v.done));
            chk({tag, ".d"},    32'(bus2.latch_d),  32'(v.d));
        end
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        bus1.req  = '0;
        bus2.req  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_pos = 0;
        m_ptr = 0;
        m_win = 0;
        m_d   = '0;
    endtask

    task automatic one_write(input logic [N-1:0] r, input string tag);
        logic seen;
        seen     = 1'b0;
        bus1.req = r;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus1.done) begin
                seen = 1'b1;
                break;
            end
        end
        bus1.req = '0;
        chk({tag, " done seen"}, 32'(seen), 32'(1));
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: position within a write of L cycles, then one idle cycle.
    task automatic model_edge();
        if (m_pos == 0) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (bus1.req[i]) begin
                    m_win = i;
                    m_d   = bus1.wdata[i*W +: W];
                    m_pos = 1;
                    break;
                end
            end
        end else if (m_pos == L) begin
            m_pos = 0;
            m_ptr = (m_win + 1) % N;
        end else begin
            m_pos++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           order[$];
        int           exp_order[5];
        logic [W-1:0] dat4[4];
        logic         prev_zero;
        logic         gap_pending;
        logic         seen;
        logic [N-1:0] eg;

        bus1.req   = '0;
        bus1.wdata = '0;
        bus2.req   = '0;
        bus2.wdata = '0;

        tv1[0] = '{req: 4'b0001, wd: 8'hA5, gnt: 4'b0000, busy: 0, en: 0, done: 0, d: 8'h00};
        tv1[1] = '{req: 4'b0001, wd: 8'hA5, gnt: 4'b0001, busy: 1, en: 0, done: 0, d: 8'hA5};
        tv1[2] = '{req: 4'b0001, wd: 8'hA5, gnt: 4'b0001, busy: 1, en: 0, done: 0, d: 8'hA5};
        tv1[3] = '{req: 4'b0001, wd: 8'h3C, gnt: 4'b0001, busy: 1, en: 1, done: 0, d: 8'hA5};
        tv1[4] = '{req: 4'b0000, wd: 8'h3C, gnt: 4'b0001, busy: 1, en: 0, done: 1, d: 8'hA5};
        tv1[5] = '{req: 4'b0000, wd: 8'h3C, gnt: 4'b0000, busy: 0, en: 0, done: 0, d: 8'hA5};
        tv1[6] = '{req: 4'b0000, wd: 8'h3C, gnt: 4'b0000, busy: 0, en: 0, done: 0, d: 8'hA5};

        tv2[0] = '{req: 4'b0001, wd: 8'h5A, gnt: 4'b0000, busy: 0, en: 0, done: 0, d: 8'h00};
        tv2[1] = '{req: 4'b0001, wd: 8'h5A, gnt: 4'b0001, busy: 1, en: 1, done: 0, d: 8'h5A};
        tv2[2] = '{req: 4'b0001, wd: 8'hC3, gnt: 4'b0001, busy: 1, en: 1, done: 0, d: 8'h5A};
        tv2[3] = '{req: 4'b0000, wd: 8'hC3, gnt: 4'b0001, busy: 1, en: 1, done: 1, d: 8'h5A};
        tv2[4] = '{req: 4'b0000, wd: 8'hC3, gnt: 4'b0000, busy: 0, en: 0, done: 0, d: 8'h5A};
        tv2[5] = '{req: 4'b0000, wd: 8'hC3, gnt: 4'b0000, busy: 0, en: 0, done: 0, d: 8'h5A};

        // single write, default windows
        do_reset();
        bus1.wdata = {8'h44, 8'h33, 8'h22, 8'h00};
        for (int k = 0; k < 7; k++) begin
            check_row($sformatf("t1c%0d", k), 1, tv1[k]);
            bus1.req        = tv1[k].req;
            bus1.wdata[W-1:0] = tv1[k].wd;
            @(posedge clk);
            #1;
        end

        // zero setup / zero hold variant
        bus2.wdata = {8'h99, 8'h88, 8'h77, 8'h00};
        for (int k = 0; k < 6; k++) begin
            check_row($sformatf("t2c%0d", k), 2, tv2[k]);
            bus2.req          = tv2[k].req;
            bus2.wdata[W-1:0] = tv2[k].wd;
            @(posedge clk);
            #1;
        end

        // all four requesting persistently from reset
        do_reset();
        dat4         = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_order    = '{0, 1, 2, 3, 0};
        bus1.wdata   = {dat4[3], dat4[2], dat4[1], dat4[0]};
        bus1.req     = 4'b1111;
        prev_zero    = 1'b1;
        gap_pending  = 1'b0;
        for (int c = 0; c < 100 && order.size() < 5; c++) begin
            @(posedge clk);
            #1;
            if (gap_pending) begin
                chk($sformatf("all4 idle gap c%0d", c), 32'({bus1.busy, bus1.gnt}), 32'(0));
                gap_pending = 1'b0;
            end
            if (bus1.done) gap_pending = 1'b1;
            if (bus1.gnt != '0 && prev_zero) begin
                chk($sformatf("all4 onehot c%0d", c), 32'($onehot(bus1.gnt)), 32'(1));
                order.push_back(oh2idx(bus1.gnt));
                if (oh2idx(bus1.gnt) >= 0)
                    chk($sformatf("all4 data c%0d", c), 32'(bus1.latch_d), 32'(dat4[oh2idx(bus1.gnt)]));
            end
            prev_zero = (bus1.gnt == '0);
        end
        chk("all4 grant count", 32'(order.size()), 32'(5));
        for (int i = 0; i < order.size(); i++)
            chk($sformatf("all4 order[%0d]", i), 32'(order[i]), 32'(exp_order[i]));

        // req drops during SETUP, write still completes
        do_reset();
        bus1.wdata = {8'h44, 8'h33, 8'h22, 8'hA5};
        bus1.req   = 4'b0001;
        @(posedge clk);
        #1;
        chk("drop busy", 32'(bus1.busy), 32'(1));
        bus1.req = '0;
        seen     = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus1.done) begin
                seen = 1'b1;
                chk("drop latch_d", 32'(bus1.latch_d), 32'(8'hA5));
                break;
            end
        end
        chk("drop done seen", 32'(seen), 32'(1));

        // push ptr to 2, then reset during OPEN
        one_write(4'b0010, "pre-reset wr1");
        bus1.req = 4'b0100;
        seen     = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus1.latch_en) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst open reached", 32'(seen), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst async en",   32'(bus1.latch_en), 32'(0));
        chk("rst async outs", 32'({bus1.gnt, bus1.busy, bus1.done, bus1.latch_d}), 32'(0));
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        bus1.req = 4'b1010;
        @(posedge clk);
        #1;
        chk("post-rst gnt",     32'(bus1.gnt),     32'(4'b0010));
        chk("post-rst latch_d", 32'(bus1.latch_d), 32'(8'h22));

        // randomized traffic against the transaction-level model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus1.req[i]) begin
                    if ($urandom_range(2) == 0) bus1.req[i] = 1'b1;
                end else if ($urandom_range(7) == 0) begin
                    bus1.req[i] = 1'b0;
                end
            end
            bus1.wdata = 32'($urandom);
            model_edge();
            @(posedge clk);
            #1;
            eg = '0;
            if (m_pos != 0) eg[m_win] = 1'b1;
            chk($sformatf("rand c%0d gnt", c),  32'(bus1.gnt),      32'(eg));
            chk($sformatf("rand c%0d busy", c), 32'(bus1.busy),     32'(m_pos != 0));
            chk($sformatf("rand c%0d en", c),   32'(bus1.latch_en), 32'(m_pos > S && m_pos <= S + O));
            chk($sformatf("rand c%0d done", c), 32'(bus1.done),     32'(m_pos == L));
            chk($sformatf("rand c%0d d", c),    32'(bus1.latch_d),  32'(m_d));
`ifdef LATCH_WR_SCHED_VERIFY_EN
            chk($sformatf("rand c%0d err", c),  32'(bus1.err),      32'(0));
`endif
        end

`ifdef LATCH_WR_SCHED_VERIFY_EN
        // readback mismatch: latch_q forced to zero while writing FF
        do_reset();
        q_zero            = 1'b1;
        bus1.wdata[W-1:0] = 8'hFF;
        bus1.req          = 4'b0001;
        seen              = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (!bus1.done) chk($sformatf("verify err quiet c%0d", c), 32'(bus1.err), 32'(0));
            if (bus1.done) begin
                seen = 1'b1;
                chk("verify err on done", 32'(bus1.err), 32'(1));
                bus1.req = '0;
                break;
            end
        end
        chk("verify done seen", 32'(seen), 32'(1));
        @(posedge clk);
        #1;
        chk("verify err pulse ends", 32'(bus1.err), 32'(0));
        q_zero = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
